// File: rtl/seq_multiplier.sv
// Shift-add sequential multiplier producing a 2N-bit HI/LO product.
// Optional MULT_SIGNED_EN adds signed_op and a sign-fix state.
module seq_multiplier #(
    parameter int N = 32,
    localparam int M = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
`ifdef MULT_SIGNED_EN
    input  logic         signed_op,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         cnt_set,
    output logic         cnt_count,
    input  logic [M-1:0] cnt_value
);

`ifdef MULT_SIGNED_EN
    typedef enum logic [2:0] {IDLE, INIT, RUN, DONE, FIX} state_t;
`else
    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;
`endif

    state_t       state_q, state_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         cnt_set_q, cnt_set_d;
    logic         cnt_count_q, cnt_count_d;
    logic [N-1:0] hi_q, hi_d;
    logic [N-1:0] lo_q, lo_d;
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] mplier_q, mplier_d;
    logic [N-1:0] mcand_q, mcand_d;
    logic [N-1:0] addend;
    logic [N:0]   sum;
    logic         last_step;
`ifdef MULT_SIGNED_EN
    logic           sign_q, sign_d;
    logic [N-1:0]   a_mag, b_mag;
    logic [2*N-1:0] prod_neg;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign cnt_set   = cnt_set_q;
    assign cnt_count = cnt_count_q;

    // Counter reads 2 before the N-th step once it has wrapped from 1.
    assign last_step = (cnt_value == M'(2));
    assign addend    = mplier_q[0] ? mcand_q : {N{1'b0}};
    assign sum       = {1'b0, acc_q} + {1'b0, addend};

`ifdef MULT_SIGNED_EN
    assign a_mag    = (signed_op && a[N-1]) ? -a : a;
    assign b_mag    = (signed_op && b[N-1]) ? -b : b;
    assign prod_neg = -{acc_q, mplier_q};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_set_q   <= 1'b0;
            cnt_count_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            mcand_q     <= '0;
`ifdef MULT_SIGNED_EN
            sign_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cnt_set_q   <= cnt_set_d;
            cnt_count_q <= cnt_count_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            acc_q       <= acc_d;
            mplier_q    <= mplier_d;
            mcand_q     <= mcand_d;
`ifdef MULT_SIGNED_EN
            sign_q      <= sign_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cnt_set_d   = cnt_set_q;
        cnt_count_d = cnt_count_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        acc_d       = acc_q;
        mplier_d    = mplier_q;
        mcand_d     = mcand_q;
`ifdef MULT_SIGNED_EN
        sign_d      = sign_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
`ifdef MULT_SIGNED_EN
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    sign_d   = signed_op & (a[N-1] ^ b[N-1]);
`else
                    mcand_d  = a;
                    mplier_d = b;
`endif
                    acc_d     = '0;
                    busy_d    = 1'b1;
                    cnt_set_d = 1'b1;
                    state_d   = INIT;
                end
            end
            INIT: begin
                cnt_set_d   = 1'b0;
                cnt_count_d = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                // The multiplier register shifts out as the low accumulator.
                acc_d    = sum[N:1];
                mplier_d = {sum[0], mplier_q[N-1:1]};
                if (last_step) begin
                    cnt_count_d = 1'b0;
`ifdef MULT_SIGNED_EN
                    state_d = FIX;
`else
                    hi_d    = sum[N:1];
                    lo_d    = {sum[0], mplier_q[N-1:1]};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
`endif
                end
            end
`ifdef MULT_SIGNED_EN
            FIX: begin
                if (sign_q) begin
                    hi_d = prod_neg[2*N-1:N];
                    lo_d = prod_neg[N-1:0];
                end else begin
                    hi_d = acc_q;
                    lo_d = mplier_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier with a behavioural down_counter.
// Vector table plus random operands against an arithmetic product model.
module tb_seq_multiplier;

    localparam int N = 32;
    localparam int M = 5;
`ifdef MULT_SIGNED_EN
    localparam int LAT = N + 2;
`else
    localparam int LAT = N + 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         sg = 1'b0;
    logic         busy, done, cnt_set, cnt_count;
    logic [N-1:0] hi, lo;
    logic [M-1:0] cnt_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef MULT_SIGNED_EN
        .signed_op (sg),
`endif
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .cnt_set   (cnt_set),
        .cnt_count (cnt_count),
        .cnt_value (cnt_q)
    );

    // Iteration counter: async set to 1, decrements mod N when counting.
    always_ff @(posedge clk or posedge cnt_set) begin
        if (cnt_set)
            cnt_q <= M'(1);
        else if (cnt_count)
            cnt_q <= cnt_q - 1'b1;
    end

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         s;
        logic [N-1:0] hi;
        logic [N-1:0] lo;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [2*N-1:0] model(logic [N-1:0] x, logic [N-1:0] y, logic s);
        logic signed [2*N-1:0] sx, sy;
        if (s) begin
            sx = $signed({{N{x[N-1]}}, x});
            sy = $signed({{N{y[N-1]}}, y});
            return sx * sy;
        end
        return {{N{1'b0}}, x} * {{N{1'b0}}, y};
    endfunction

    task automatic chk(string nm, logic [2*N-1:0] act, logic [2*N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [N-1:0] ai, input logic [N-1:0] bi,
                          input logic s, input int glitch_k,
                          output logic [N-1:0] rh, output logic [N-1:0] rl,
                          output int lat, output int nset, output int ncnt,
                          output logic tail_ok);
        @(negedge clk);
        a = ai; b = bi; sg = s; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; sg = ~s;
        lat = -1; nset = 0; ncnt = 0; rh = '0; rl = '0;
        for (int k = 0; k < 4*N; k++) begin
            if (k > 0) @(negedge clk);
            if (k == glitch_k) begin
                start = 1'b1; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            nset += int'(cnt_set);
            ncnt += int'(cnt_count);
            if (done) begin
                lat = k; rh = hi; rl = lo;
                break;
            end
        end
        @(negedge clk);
        tail_ok = !done && !busy;
        start = 1'b0;
    endtask

    task automatic do_op(string nm, logic [N-1:0] ai, logic [N-1:0] bi,
                         logic s, int glitch_k, logic [2*N-1:0] exp);
        logic [N-1:0] rh, rl;
        int lat, nset, ncnt;
        logic tail_ok;
        run_op(ai, bi, s, glitch_k, rh, rl, lat, nset, ncnt, tail_ok);
        chk({nm, " product"}, {rh, rl}, exp);
        chk({nm, " latency"}, 64'(lat), 64'(LAT));
        chk({nm, " cnt_set cycles"}, 64'(nset), 64'd1);
        chk({nm, " cnt_count cycles"}, 64'(ncnt), 64'(N));
        chk({nm, " idle after done"}, 64'(tail_ok), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] ra, rb;
        logic         rs;

        vecs.push_back('{32'd3, 32'd5, 1'b0, 32'h0000_0000, 32'h0000_000F});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{32'hFFFF_FFFD, 32'd5, 1'b0, 32'h0000_0004, 32'hFFFF_FFF1});
        vecs.push_back('{32'h0, 32'h1234_5678, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{32'd1, 32'h8000_0000, 1'b0, 32'h0, 32'h8000_0000});
`ifdef MULT_SIGNED_EN
        vecs.push_back('{32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0});
`endif
        vecs.push_back('{32'h8000_0000, 32'd2, 1'b0, 32'h0000_0001, 32'h0});

        #12;
        chk("reset ctrl", 64'({busy, done, cnt_set, cnt_count}), 64'd0);
        chk("reset hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                  -1, {vecs[i].hi, vecs[i].lo});

        // Abort mid-run: outputs clear without waiting for a clock edge.
        @(negedge clk);
        a = 32'h1234; b = 32'h5678; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun reset ctrl", 64'({busy, done, cnt_set, cnt_count}), 64'd0);
        chk("midrun reset hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after reset 7x6", 32'd7, 32'd6, 1'b0, -1, 64'd42);

        do_op("start ignored in run", 32'd7, 32'd9, 1'b0, 10, 64'd63);
        do_op("start ignored in done", 32'd11, 32'd13, 1'b0, LAT, 64'd143);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
`ifdef MULT_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            do_op($sformatf("rand%0d", i), ra, rb, rs, -1, model(ra, rb, rs));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
